// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: tag width and the cache controller state encoding.
package lc3b_types;

  typedef logic [8:0] cache_tag;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state;

endpackage

// File: rtl/cache_control.sv
// Two-way write-back cache controller: hit handling, victim writeback and line fill.
import lc3b_types::*;

module cache_control (
  input  logic clk,
  input  logic reset,
  input  logic mem_read,
  input  logic mem_write,
  input  logic hit0,
  input  logic hit1,
  input  logic dirty0,
  input  logic dirty1,
  input  logic lru_out,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic load_data0,
  output logic load_data1,
  output logic load_tag0,
  output logic load_tag1,
  output logic load_valid0,
  output logic load_valid1,
  output logic load_dirty0,
  output logic load_dirty1,
  output logic dirty_in,
  output logic load_lru,
  output logic lru_in,
  output logic data_sel,
  output logic pmem_addr_sel
);

  cache_state state;
  cache_state next_state;
  logic       request;
  logic       victim_dirty;

  assign request      = mem_read | mem_write;
  assign victim_dirty = lru_out ? dirty1 : dirty0;

  // State register; reset returns to CHECK immediately, discarding any miss in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CHECK;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode; outputs are forced low while reset is held.
  always_comb begin
    next_state    = state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    load_data0    = 1'b0;
    load_data1    = 1'b0;
    load_tag0     = 1'b0;
    load_tag1     = 1'b0;
    load_valid0   = 1'b0;
    load_valid1   = 1'b0;
    load_dirty0   = 1'b0;
    load_dirty1   = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    data_sel      = 1'b0;
    pmem_addr_sel = 1'b0;

    if (reset) begin
      next_state = CHECK;
    end else begin
      case (state)
        CHECK: begin
          if (request && (hit0 || hit1)) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            lru_in   = hit0 ? 1'b1 : 1'b0;
            // A write (including read+write) merges CPU data and marks the line dirty.
            if (mem_write) begin
              dirty_in    = 1'b1;
              data_sel    = 1'b0;
              load_data0  = hit0;
              load_dirty0 = hit0;
              load_data1  = ~hit0;
              load_dirty1 = ~hit0;
            end else begin
              dirty_in = 1'b0;
            end
          end else if (request) begin
            next_state = victim_dirty ? WRITEBACK : ALLOCATE;
          end else begin
            next_state = CHECK;
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          if (pmem_resp) begin
            next_state = ALLOCATE;
          end else begin
            next_state = WRITEBACK;
          end
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            data_sel    = 1'b1;
            dirty_in    = 1'b0;
            load_data0  = ~lru_out;
            load_tag0   = ~lru_out;
            load_valid0 = ~lru_out;
            load_dirty0 = ~lru_out;
            load_data1  = lru_out;
            load_tag1   = lru_out;
            load_valid1 = lru_out;
            load_dirty1 = lru_out;
            next_state  = CHECK;
          end else begin
            next_state = ALLOCATE;
          end
        end
        default: begin
          next_state = CHECK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: vector table for CHECK-state decode plus miss/reset sequences.
module tb_cache_control;

  logic clk = 1'b0;
  logic reset, mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru_out, pmem_resp;
  logic mem_resp, pmem_read, pmem_write;
  logic load_data0, load_data1, load_tag0, load_tag1;
  logic load_valid0, load_valid1, load_dirty0, load_dirty1;
  logic dirty_in, load_lru, lru_in, data_sel, pmem_addr_sel;
  logic [15:0] outs;

  localparam logic [15:0] MR  = 16'h8000, PR  = 16'h4000, PW   = 16'h2000, LD0  = 16'h1000;
  localparam logic [15:0] LD1 = 16'h0800, LT0 = 16'h0400, LT1  = 16'h0200, LV0  = 16'h0100;
  localparam logic [15:0] LV1 = 16'h0080, LY0 = 16'h0040, LY1  = 16'h0020, DI   = 16'h0010;
  localparam logic [15:0] LL  = 16'h0008, LI  = 16'h0004, DS   = 16'h0002, PAS  = 16'h0001;

  typedef struct {
    string       name;
    logic        rst, rd, wr, h0, h1, d0, d1, lru, presp;
    logic [15:0] exp;
  } vec_t;

  logic [15:0] sb_q[$];
  int pass_cnt = 0;
  int chk_cnt  = 0;

  cache_control dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1),
    .lru_out(lru_out), .pmem_resp(pmem_resp), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .load_data0(load_data0), .load_data1(load_data1),
    .load_tag0(load_tag0), .load_tag1(load_tag1),
    .load_valid0(load_valid0), .load_valid1(load_valid1),
    .load_dirty0(load_dirty0), .load_dirty1(load_dirty1),
    .dirty_in(dirty_in), .load_lru(load_lru), .lru_in(lru_in),
    .data_sel(data_sel), .pmem_addr_sel(pmem_addr_sel)
  );

  assign outs = {mem_resp, pmem_read, pmem_write, load_data0, load_data1, load_tag0, load_tag1,
                 load_valid0, load_valid1, load_dirty0, load_dirty1, dirty_in, load_lru,
                 lru_in, data_sel, pmem_addr_sel};

  always #5 clk = ~clk;

  // Drive one cycle of inputs after the edge, queue the expectation, compare mid-cycle.
  task automatic step(input vec_t v);
    logic [15:0] exp;
    @(posedge clk);
    #1;
    reset = v.rst; mem_read = v.rd; mem_write = v.wr; hit0 = v.h0; hit1 = v.h1;
    dirty0 = v.d0; dirty1 = v.d1; lru_out = v.lru; pmem_resp = v.presp;
    sb_q.push_back(v.exp);
    @(negedge clk);
    exp = sb_q.pop_front();
    chk_cnt++;
    if (outs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", v.name, outs, exp);
  endtask

  function automatic vec_t mk(string n, logic rst, logic rd, logic wr, logic h0, logic h1,
                              logic d0, logic d1, logic lru, logic presp, logic [15:0] exp);
    vec_t v;
    v.name = n; v.rst = rst; v.rd = rd; v.wr = wr; v.h0 = h0; v.h1 = h1;
    v.d0 = d0; v.d1 = d1; v.lru = lru; v.presp = presp; v.exp = exp;
    return v;
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
    dirty0 = 1'b0; dirty1 = 1'b0; lru_out = 1'b0; pmem_resp = 1'b0;

    // CHECK-state decode table: none of these leave CHECK.
    tbl.push_back(mk("reset_hold_hit",  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(mk("idle",            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(mk("read_hit1",       1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MR|LL));
    tbl.push_back(mk("read_hit0",       1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, MR|LL|LI));
    tbl.push_back(mk("read_both_hit",   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MR|LL|LI));
    tbl.push_back(mk("write_hit0",      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MR|LD0|LY0|DI|LL|LI));
    tbl.push_back(mk("write_hit1",      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MR|LD1|LY1|DI|LL));
    tbl.push_back(mk("rdwr_hit1",       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MR|LD1|LY1|DI|LL));
    tbl.push_back(mk("idle_hits",       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(mk("idle_presp",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Clean read miss on way 1: three waiting ALLOCATE cycles, fill, then hit.
    step(mk("clean_miss",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000));
    for (int i = 0; i < 3; i++)
      step(mk("clean_alloc_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, PR));
    step(mk("clean_fill",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, PR|LD1|LT1|LV1|LY1|DS));
    step(mk("clean_rehit",      1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MR|LL));

    // Dirty write miss on way 0: writeback, fill, then merging write hit.
    step(mk("dirty_miss",       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000));
    step(mk("dirty_wb_wait",    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, PW|PAS));
    step(mk("dirty_wb_resp",    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, PW|PAS));
    step(mk("dirty_alloc_wait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, PR));
    step(mk("dirty_fill",       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, PR|LD0|LT0|LV0|LY0|DS));
    step(mk("dirty_rehit",      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MR|LD0|LY0|DI|LL|LI));

    // Reset asserted mid-ALLOCATE while pmem_resp is high: nothing may load.
    step(mk("rst_miss",         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000));
    step(mk("rst_alloc",        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, PR));
    step(mk("rst_mid_alloc",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000));
    step(mk("rst_after_idle",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000));
    step(mk("rst_after_hit",    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MR|LL));

    // Request dropped during WRITEBACK: transaction finishes, no mem_resp.
    step(mk("drop_miss",        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000));
    step(mk("drop_wb_wait",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, PW|PAS));
    step(mk("drop_wb_resp",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, PW|PAS));
    step(mk("drop_alloc_wait",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, PR));
    step(mk("drop_fill",        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, PR|LD1|LT1|LV1|LY1|DS));
    step(mk("drop_back_check",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
